branch_predictor: RTL and testbench



---
 rtl/branch_predictor.sv | 104 ++++++++++
 tb/tb_branch_predictor.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with 2-bit counters, F->D prediction register.
// Optional statistics counters are enabled by defining BP_STATS_EN.
module branch_predictor #(
  parameter int unsigned IDX_BITS = 4,
  parameter int unsigned TAG_BITS = 8,
  parameter logic [1:0]  CTR_INIT = 2'b01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pcF,
  input  logic        stallD,
  input  logic        flushD,
  output logic        predtakenF,
  output logic [31:0] predtargetF,
  input  logic        branchD,
  input  logic [31:0] pcD,
  input  logic        equalD,
  input  logic [31:0] pcbranchD,
  output logic        predtakenD,
  output logic        mispredictD,
`ifdef BP_STATS_EN
  output logic [15:0] brcount,
  output logic [15:0] mispcount,
`endif
  output logic [31:0] recoverpcD
);

  localparam int unsigned ENTRIES = 2 ** IDX_BITS;
  localparam int unsigned TAG_LSB = IDX_BITS;
  localparam int unsigned TAG_MSB = IDX_BITS + TAG_BITS - 1;

  logic                valid  [ENTRIES];
  logic [TAG_BITS-1:0] tagMem [ENTRIES];
  logic [31:0]         target [ENTRIES];
  logic [1:0]          ctr    [ENTRIES];

  logic [IDX_BITS-1:0] idxF, idxD;
  logic [TAG_BITS-1:0] tagF, tagD;
  logic                hitF, hitD, updateEn;
  logic                unusedPcBits;

  assign idxF = pcF[IDX_BITS-1:0];
  assign tagF = pcF[TAG_MSB:TAG_LSB];
  assign idxD = pcD[IDX_BITS-1:0];
  assign tagD = pcD[TAG_MSB:TAG_LSB];
  assign unusedPcBits = ^{pcF[31:TAG_MSB+1], pcD[31:TAG_MSB+1]};

  // Fetch-side lookup reads the array before any same-cycle update lands.
  assign hitF        = valid[idxF] && (tagMem[idxF] == tagF);
  assign predtakenF  = hitF && ctr[idxF][1];
  assign predtargetF = hitF ? target[idxF] : 32'd0;

  assign hitD        = valid[idxD] && (tagMem[idxD] == tagD);
  assign updateEn    = branchD && !stallD;
  assign mispredictD = branchD && (predtakenD != equalD);
  assign recoverpcD  = equalD ? pcbranchD : pcD + 32'd1;

  // F->D prediction register
  always_ff @(posedge clk) begin
    if (reset)        predtakenD <= 1'b0;
    else if (flushD)  predtakenD <= 1'b0;
    else if (!stallD) predtakenD <= predtakenF;
  end

  // BTB training from decode; taken misses allocate, not-taken misses are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid[i]  <= 1'b0;
        tagMem[i] <= '0;
        target[i] <= 32'd0;
        ctr[i]    <= CTR_INIT;
      end
    end else if (updateEn) begin
      if (hitD) begin
        if (equalD) begin
          if (ctr[idxD] != 2'b11) ctr[idxD] <= ctr[idxD] + 2'd1;
          target[idxD] <= pcbranchD;
        end else if (ctr[idxD] != 2'b00) begin
          ctr[idxD] <= ctr[idxD] - 2'd1;
        end
      end else if (equalD) begin
        valid[idxD]  <= 1'b1;
        tagMem[idxD] <= tagD;
        target[idxD] <= pcbranchD;
        ctr[idxD]    <= 2'b10;
      end
    end
  end

`ifdef BP_STATS_EN
  // Saturating branch and mispredict counters
  always_ff @(posedge clk) begin
    if (reset) begin
      brcount   <= 16'd0;
      mispcount <= 16'd0;
    end else begin
      if (updateEn && brcount != 16'hFFFF) brcount <= brcount + 16'd1;
      if (mispredictD && !stallD && mispcount != 16'hFFFF) mispcount <= mispcount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (BP_STATS_EN section tracks the RTL macro).
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset, stallD, flushD, branchD, equalD;
  logic [31:0] pcF, pcD, pcbranchD;
  logic        predtakenF, predtakenD, mispredictD;
  logic [31:0] predtargetF, recoverpcD;
`ifdef BP_STATS_EN
  logic [15:0] brcount, mispcount;
`endif

  int nVec  = 0;
  int nFail = 0;

  branch_predictor dut (
    .clk(clk), .reset(reset), .pcF(pcF), .stallD(stallD), .flushD(flushD),
    .predtakenF(predtakenF), .predtargetF(predtargetF), .branchD(branchD),
    .pcD(pcD), .equalD(equalD), .pcbranchD(pcbranchD), .predtakenD(predtakenD),
    .mispredictD(mispredictD),
`ifdef BP_STATS_EN
    .brcount(brcount), .mispcount(mispcount),
`endif
    .recoverpcD(recoverpcD)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required < 200000", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stallD = 0; flushD = 0; branchD = 0; equalD = 0; pcD = 0; pcbranchD = 0;
  endtask

  task automatic drive(input logic [31:0] pd, input logic eq, input logic [31:0] tgt);
    branchD = 1; pcD = pd; equalD = eq; pcbranchD = tgt;
  endtask

  task automatic test_reset();
    reset = 1; pcF = 32'h10; idle();
    tick(); tick();
    reset = 0; #1;
    nVec++; if (predtakenF !== 1'b0) begin nFail++; $display("FAIL reset_predtakenF got %b exp 0", predtakenF); end
    nVec++; if (predtargetF !== 32'h0) begin nFail++; $display("FAIL reset_predtargetF got %h exp 0", predtargetF); end
    nVec++; if (predtakenD !== 1'b0) begin nFail++; $display("FAIL reset_predtakenD got %b exp 0", predtakenD); end
    drive(32'h10, 1, 32'h20); #1;
    nVec++; if (mispredictD !== 1'b1) begin nFail++; $display("FAIL reset_mispredict got %b exp 1", mispredictD); end
    nVec++; if (recoverpcD !== 32'h20) begin nFail++; $display("FAIL reset_recoverpc got %h exp 20", recoverpcD); end
  endtask

  task automatic test_counter();
    // branch at 0x10 is being driven taken: allocate with ctr=2
    tick();
    nVec++; if (predtakenF !== 1'b1) begin nFail++; $display("FAIL alloc_predtakenF got %b exp 1", predtakenF); end
    nVec++; if (predtargetF !== 32'h20) begin nFail++; $display("FAIL alloc_predtargetF got %h exp 20", predtargetF); end
    nVec++; if (predtakenD !== 1'b0) begin nFail++; $display("FAIL alloc_predtakenD got %b exp 0", predtakenD); end
    tick(); // ctr 3
    nVec++; if (predtakenD !== 1'b1) begin nFail++; $display("FAIL ctr3_predtakenD got %b exp 1", predtakenD); end
    nVec++; if (mispredictD !== 1'b0) begin nFail++; $display("FAIL ctr3_mispredict got %b exp 0", mispredictD); end
    tick(); // ctr stays 3
    drive(32'h10, 0, 32'h0); #1;
    nVec++; if (mispredictD !== 1'b1) begin nFail++; $display("FAIL nt_mispredict got %b exp 1", mispredictD); end
    nVec++; if (recoverpcD !== 32'h11) begin nFail++; $display("FAIL nt_recoverpc got %h exp 11", recoverpcD); end
    tick(); // ctr 2
    nVec++; if (predtakenF !== 1'b1) begin nFail++; $display("FAIL ctr2_predtakenF got %b exp 1", predtakenF); end
    tick(); // ctr 1
    nVec++; if (predtakenF !== 1'b0) begin nFail++; $display("FAIL ctr1_predtakenF got %b exp 0", predtakenF); end
    tick(); // ctr 0, entry still valid
    nVec++; if (predtakenF !== 1'b0) begin nFail++; $display("FAIL ctr0_predtakenF got %b exp 0", predtakenF); end
    nVec++; if (predtargetF !== 32'h20) begin nFail++; $display("FAIL ctr0_validtarget got %h exp 20", predtargetF); end
    tick(); // saturates at 0
    drive(32'h10, 1, 32'h24);
    tick(); // hit taken: ctr 1, target updated
    nVec++; if (predtakenF !== 1'b0) begin nFail++; $display("FAIL ctr0to1_predtakenF got %b exp 0", predtakenF); end
    nVec++; if (predtargetF !== 32'h24) begin nFail++; $display("FAIL hit_target_update got %h exp 24", predtargetF); end
    idle(); pcD = 32'hFFFF_FFFF; #1;
    nVec++; if (mispredictD !== 1'b0) begin nFail++; $display("FAIL nobranch_mispredict got %b exp 0", mispredictD); end
    nVec++; if (recoverpcD !== 32'h0) begin nFail++; $display("FAIL wrap_recoverpc got %h exp 0", recoverpcD); end
  endtask

  task automatic test_no_alloc();
    idle(); drive(32'h33, 0, 32'h55); pcF = 32'h33;
    tick();
    idle(); #1;
    nVec++; if (predtakenF !== 1'b0) begin nFail++; $display("FAIL noalloc_predtakenF got %b exp 0", predtakenF); end
    nVec++; if (predtargetF !== 32'h0) begin nFail++; $display("FAIL noalloc_predtargetF got %h exp 0", predtargetF); end
  endtask

  task automatic test_alias();
    drive(32'h005, 1, 32'h40); pcF = 32'h005;
    tick();
    nVec++; if (predtargetF !== 32'h40) begin nFail++; $display("FAIL alias_first got %h exp 40", predtargetF); end
    drive(32'h105, 1, 32'h80);
    tick();
    idle(); #1;
    nVec++; if (predtakenF !== 1'b0) begin nFail++; $display("FAIL alias_evicted got %b exp 0", predtakenF); end
    pcF = 32'h105; #1;
    nVec++; if (predtakenF !== 1'b1) begin nFail++; $display("FAIL alias_new_taken got %b exp 1", predtakenF); end
    nVec++; if (predtargetF !== 32'h80) begin nFail++; $display("FAIL alias_new_target got %h exp 80", predtargetF); end
  endtask

  task automatic test_collision_stall_flush();
    pcF = 32'h07; drive(32'h07, 1, 32'h70); #1;
    nVec++; if (predtakenF !== 1'b0) begin nFail++; $display("FAIL coll_same_cycle got %b exp 0", predtakenF); end
    tick();
    nVec++; if (predtakenF !== 1'b1) begin nFail++; $display("FAIL coll_next_cycle got %b exp 1", predtakenF); end
    nVec++; if (predtargetF !== 32'h70) begin nFail++; $display("FAIL coll_target got %h exp 70", predtargetF); end
    idle();
    tick();
    nVec++; if (predtakenD !== 1'b1) begin nFail++; $display("FAIL coll_predtakenD got %b exp 1", predtakenD); end
    // stall: predtakenD held at 1 although predtakenF=0, and no allocation at 0x33
    stallD = 1; pcF = 32'h10; drive(32'h33, 1, 32'h99);
    tick();
    nVec++; if (predtakenD !== 1'b1) begin nFail++; $display("FAIL stall_hold got %b exp 1", predtakenD); end
    idle(); pcF = 32'h33; #1;
    nVec++; if (predtakenF !== 1'b0) begin nFail++; $display("FAIL stall_noupdate got %b exp 0", predtakenF); end
    // flush clears predtakenD but still trains
    pcF = 32'h07; flushD = 1; drive(32'h33, 1, 32'h99);
    tick();
    nVec++; if (predtakenD !== 1'b0) begin nFail++; $display("FAIL flush_clear got %b exp 0", predtakenD); end
    idle(); pcF = 32'h33; #1;
    nVec++; if (predtargetF !== 32'h99) begin nFail++; $display("FAIL flush_trains got %h exp 99", predtargetF); end
    // reset with a simultaneous update discards everything
    reset = 1; drive(32'h07, 1, 32'h77); pcF = 32'h07;
    tick();
    reset = 0; idle(); #1;
    nVec++; if (predtakenF !== 1'b0) begin nFail++; $display("FAIL reset_wipe got %b exp 0", predtakenF); end
    nVec++; if (predtargetF !== 32'h0) begin nFail++; $display("FAIL reset_wipe_target got %h exp 0", predtargetF); end
  endtask

`ifdef BP_STATS_EN
  task automatic test_stats();
    logic [4:0] outcomes;
    outcomes = 5'b00101;
    pcF = 32'h0B;
    for (int i = 0; i < 5; i++) begin
      drive(32'h0A, outcomes[i], 32'hA0);
      tick();
    end
    stallD = 1; drive(32'h0A, 1, 32'hA0);
    tick();
    idle(); #1;
    nVec++; if (brcount !== 16'd5) begin nFail++; $display("FAIL stats_brcount got %0d exp 5", brcount); end
    nVec++; if (mispcount !== 16'd2) begin nFail++; $display("FAIL stats_mispcount got %0d exp 2", mispcount); end
    reset = 1;
    tick();
    reset = 0; #1;
    nVec++; if (brcount !== 16'd0 || mispcount !== 16'd0) begin
      nFail++; $display("FAIL stats_reset got %0d/%0d exp 0/0", brcount, mispcount);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_counter();
    test_no_alloc();
    test_alias();
    test_collision_stall_flush();
`ifdef BP_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
